// File: rtl/rv32i_types.sv
// Shared RV32I cache/memory types used by the I-cache and D-cache line
// adaptors and by the memory arbiter.
package rv32i_types;

   localparam int S_LINE     = 256;
   localparam int S_BURST    = 64;
   localparam int LINE_BEATS = S_LINE / S_BURST;

   typedef logic [31:0]         rv32i_word;
   typedef logic [S_LINE-1:0]   llc_cacheline;
   typedef logic [S_BURST-1:0]  burst_word;

endpackage

// File: rtl/icache_line_adaptor_if.sv
// Physical-memory burst bus between a line adaptor (master) and the
// memory arbiter or physical memory (slave).
interface icache_line_adaptor_if;
   import rv32i_types::*;

   rv32i_word address_o;
   logic      read_o;
   logic      write_o;
   burst_word burst_o;
   burst_word burst_i;
   logic      resp_i;

   modport master (
      output address_o, read_o, write_o, burst_o,
      input  burst_i, resp_i
   );

   modport slave (
      input  address_o, read_o, write_o, burst_o,
      output burst_i, resp_i
   );

endinterface

// File: rtl/icache_line_adaptor.sv
// Converts 256-bit I-cache line transfers into four ascending 64-bit beats
// on the memory burst bus. Every output comes from a register or from the
// state register alone, so no input reaches an output combinationally.
module icache_line_adaptor
   import rv32i_types::*;
(
   input  logic                   clk,
   input  logic                   rst,
   input  rv32i_word              address_i,
   input  logic                   read_i,
   input  logic                   write_i,
   input  llc_cacheline           line_i,
   output llc_cacheline           line_o,
   output logic                   resp_o,
   icache_line_adaptor_if.master  mem
);

   typedef enum logic [1:0] {
      IDLE,
      RD_BURST,
      WR_BURST,
      DONE
   } line_adaptor_state_t;

   line_adaptor_state_t                    state_q;
   logic [1:0]                             cnt_q;
   rv32i_word                              addr_q;
   logic [LINE_BEATS-1:0][S_BURST-1:0]     lineBeats_q;
   logic [LINE_BEATS-1:0][S_BURST-1:0]     writeBuf_q;

   // Main FSM: accepts a request in IDLE (read wins over write), counts
   // acknowledged beats through the burst, then spends one cycle in DONE.
   // The read line lives in its own register so write-backs never disturb it.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         addr_q      <= '0;
         lineBeats_q <= '0;
         writeBuf_q  <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (read_i) begin
                  addr_q  <= address_i & 32'hFFFF_FFE0;
                  state_q <= RD_BURST;
               end else if (write_i) begin
                  addr_q     <= address_i & 32'hFFFF_FFE0;
                  writeBuf_q <= line_i;
                  state_q    <= WR_BURST;
               end
            end
            RD_BURST: begin
               if (mem.resp_i) begin
                  lineBeats_q[cnt_q] <= mem.burst_i;
                  cnt_q              <= cnt_q + 2'd1;
                  if (cnt_q == 2'd3) begin
                     state_q <= DONE;
                  end
               end
            end
            WR_BURST: begin
               if (mem.resp_i) begin
                  cnt_q <= cnt_q + 2'd1;
                  if (cnt_q == 2'd3) begin
                     state_q <= DONE;
                  end
               end
            end
            DONE: begin
               cnt_q   <= '0;
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   // Outputs decoded purely from registered state.
   always_comb begin
      resp_o      = (state_q == DONE);
      line_o      = lineBeats_q;
      mem.address_o = addr_q;
      mem.read_o  = (state_q == RD_BURST);
      mem.write_o = (state_q == WR_BURST);
      mem.burst_o = '0;
      if (state_q == WR_BURST) begin
         mem.burst_o = writeBuf_q[cnt_q];
      end
   end

endmodule

// File: tb/tb_icache_line_adaptor.sv
// Self-checking bench for icache_line_adaptor: directed vector table,
// hand-written corner sequences and randomized transactions compared
// against a transaction-level model of the adaptor.
module tb_icache_line_adaptor;
   import rv32i_types::*;

   logic         clk = 1'b0;
   logic         rst;
   rv32i_word    address_i;
   logic         read_i;
   logic         write_i;
   llc_cacheline line_i;
   llc_cacheline line_o;
   logic         resp_o;

   icache_line_adaptor_if busIf();

   icache_line_adaptor dut (
      .clk       (clk),
      .rst       (rst),
      .address_i (address_i),
      .read_i    (read_i),
      .write_i   (write_i),
      .line_i    (line_i),
      .line_o    (line_o),
      .resp_o    (resp_o),
      .mem       (busIf)
   );

   // Free-running clock, 10 time units per cycle.
   always #5 clk = ~clk;

   // Hard time limit so the run can never hang.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   typedef struct {
      bit                  isRd;
      rv32i_word           addr;
      llc_cacheline        wline;
      logic [15:0]         pat;
      int                  lat;
      logic [3:0][63:0]    beats;
      llc_cacheline        expLine;
   } vec_t;

   int           checks   = 0;
   int           failures = 0;
   llc_cacheline lastLine;
   vec_t         vecs[3];

   // One comparison: counts it and reports a mismatch.
   task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Runs one whole line transaction. Called at the negedge of the IDLE
   // acceptance cycle T0; pat bit c-1 is resp_i during burst cycle Tc;
   // resp_o is expected exactly at cycle lat. Returns at the negedge of the
   // IDLE cycle following DONE, which may serve as the next T0.
   task automatic applyStimulus(input bit isRd, input bit holdWr, input rv32i_word addr,
                                input llc_cacheline wline, input logic [15:0] pat, input int lat,
                                input logic [3:0][63:0] beats, input llc_cacheline expLine,
                                input string tag);
      int        beatIdx;
      rv32i_word expAddr;
      expAddr      = {addr[31:5], 5'b0};
      read_i       = isRd;
      write_i      = !isRd || holdWr;
      address_i    = addr;
      line_i       = wline;
      busIf.resp_i = 1'b0;
      beatIdx      = 0;
      for (int c = 1; c < lat; c++) begin
         @(negedge clk);
         checkOutput({tag, "_addr"}, busIf.address_o, expAddr);
         checkOutput({tag, "_readReq"}, busIf.read_o, isRd);
         checkOutput({tag, "_writeReq"}, busIf.write_o, !isRd);
         checkOutput({tag, "_earlyResp"}, resp_o, 1'b0);
         if (isRd) begin
            checkOutput({tag, "_burstIdle"}, busIf.burst_o, 64'd0);
         end else begin
            checkOutput($sformatf("%s_wbeat%0d", tag, beatIdx), busIf.burst_o, wline[64*beatIdx +: 64]);
         end
         busIf.resp_i  = pat[c-1];
         busIf.burst_i = (pat[c-1] && beatIdx < 4) ? beats[beatIdx] : {$urandom, $urandom};
         if (pat[c-1]) beatIdx++;
      end
      @(negedge clk);
      busIf.resp_i = 1'b0;
      read_i       = 1'b0;
      write_i      = holdWr;
      checkOutput({tag, "_resp"}, resp_o, 1'b1);
      checkOutput({tag, "_readDone"}, busIf.read_o, 1'b0);
      checkOutput({tag, "_writeDone"}, busIf.write_o, 1'b0);
      checkOutput({tag, "_burstDone"}, busIf.burst_o, 64'd0);
      checkOutput({tag, "_line"}, line_o, expLine);
      checkOutput({tag, "_addrDone"}, busIf.address_o, expAddr);
      @(negedge clk);
      checkOutput({tag, "_respPulse"}, resp_o, 1'b0);
      checkOutput({tag, "_idleRead"}, busIf.read_o, 1'b0);
      checkOutput({tag, "_idleWrite"}, busIf.write_o, 1'b0);
      checkOutput({tag, "_lineHold"}, line_o, expLine);
      lastLine = expLine;
   endtask

   // Main sequence: reset, vector table, corner cases, random traffic.
   initial begin
      logic [3:0][63:0] beats;
      logic [15:0]      pat;
      llc_cacheline     wline;
      llc_cacheline     expLine;
      int               len;
      bit               isRd;

      vecs[0] = '{1'b1, 32'h0000_1234, '0, 16'b1111, 5,
                  {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                   64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111},
                  {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                   64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111}};
      vecs[1] = '{1'b1, 32'hDEAD_BEEF, '0, 16'b101_1001, 8,
                  {64'h8888_8888_8888_8888, 64'h7777_7777_7777_7777,
                   64'h6666_6666_6666_6666, 64'h5555_5555_5555_5555},
                  {64'h8888_8888_8888_8888, 64'h7777_7777_7777_7777,
                   64'h6666_6666_6666_6666, 64'h5555_5555_5555_5555}};
      vecs[2] = '{1'b0, 32'h0000_101F,
                  {64'hDDDD_0000_0000_000D, 64'hCCCC_0000_0000_000C,
                   64'hBBBB_0000_0000_000B, 64'hAAAA_0000_0000_000A},
                  16'b1111, 5, '0,
                  {64'h8888_8888_8888_8888, 64'h7777_7777_7777_7777,
                   64'h6666_6666_6666_6666, 64'h5555_5555_5555_5555}};

      rst           = 1'b1;
      read_i        = 1'b0;
      write_i       = 1'b0;
      address_i     = '0;
      line_i        = '0;
      busIf.resp_i  = 1'b0;
      busIf.burst_i = '0;
      lastLine      = '0;
      repeat (2) @(negedge clk);
      checkOutput("rst_line", line_o, 256'd0);
      checkOutput("rst_resp", resp_o, 1'b0);
      checkOutput("rst_read", busIf.read_o, 1'b0);
      checkOutput("rst_write", busIf.write_o, 1'b0);
      checkOutput("rst_burst", busIf.burst_o, 64'd0);
      checkOutput("rst_addr", busIf.address_o, 32'd0);
      rst = 1'b0;

      for (int i = 0; i < 3; i++) begin
         applyStimulus(vecs[i].isRd, 1'b0, vecs[i].addr, vecs[i].wline, vecs[i].pat,
                       vecs[i].lat, vecs[i].beats, vecs[i].expLine, $sformatf("vec%0d", i));
      end

      // Read and write together: read first, write accepted right after.
      beats = {64'h0F0F_0F0F_0F0F_0F0F, 64'h0E0E_0E0E_0E0E_0E0E,
               64'h0D0D_0D0D_0D0D_0D0D, 64'h0C0C_0C0C_0C0C_0C0C};
      applyStimulus(1'b1, 1'b1, 32'h0000_2040, {8{32'hCAFE_F00D}}, 16'b1111, 5, beats,
                    beats, "bothRd");
      applyStimulus(1'b0, 1'b0, 32'h0000_2040, {8{32'hCAFE_F00D}}, 16'b1111, 5, beats,
                    beats, "bothWr");

      // Stray resp_i while idle must not move the beat counter.
      for (int i = 0; i < 3; i++) begin
         busIf.resp_i  = 1'b1;
         busIf.burst_i = {$urandom, $urandom};
         @(negedge clk);
         checkOutput("stray_read", busIf.read_o, 1'b0);
         checkOutput("stray_resp", resp_o, 1'b0);
         checkOutput("stray_line", line_o, lastLine);
      end
      busIf.resp_i = 1'b0;
      beats = {64'hA3A3_A3A3_A3A3_A3A3, 64'hA2A2_A2A2_A2A2_A2A2,
               64'hA1A1_A1A1_A1A1_A1A1, 64'hA0A0_A0A0_A0A0_A0A0};
      applyStimulus(1'b1, 1'b0, 32'h0000_3000, '0, 16'b1111, 5, beats, beats, "afterStray");

      // Reset after two read beats aborts the burst.
      read_i    = 1'b1;
      address_i = 32'h0000_4444;
      @(negedge clk);
      busIf.resp_i  = 1'b1;
      busIf.burst_i = 64'h1234_5678_9ABC_DEF0;
      @(negedge clk);
      busIf.burst_i = 64'h0FED_CBA9_8765_4321;
      @(negedge clk);
      rst           = 1'b1;
      read_i        = 1'b0;
      busIf.burst_i = 64'hFFFF_FFFF_FFFF_FFFF;
      @(negedge clk);
      checkOutput("midRst_read", busIf.read_o, 1'b0);
      checkOutput("midRst_line", line_o, 256'd0);
      checkOutput("midRst_resp", resp_o, 1'b0);
      checkOutput("midRst_addr", busIf.address_o, 32'd0);
      rst          = 1'b0;
      busIf.resp_i = 1'b0;
      @(negedge clk);
      checkOutput("postRst_resp", resp_o, 1'b0);
      checkOutput("postRst_read", busIf.read_o, 1'b0);
      lastLine = '0;
      beats = {64'hB3B3_B3B3_B3B3_B3B3, 64'hB2B2_B2B2_B2B2_B2B2,
               64'hB1B1_B1B1_B1B1_B1B1, 64'hB0B0_B0B0_B0B0_B0B0};
      applyStimulus(1'b1, 1'b0, 32'h0000_4444, '0, 16'b1001_0101, 9, beats, beats, "postRstRd");

      // Random transactions with random gaps and idle stray acknowledges.
      for (int n = 0; n < 40; n++) begin
         isRd = ($urandom_range(0, 1) == 1);
         for (int b = 0; b < 4; b++) beats[b] = {$urandom, $urandom};
         for (int w = 0; w < 8; w++) wline[32*w +: 32] = $urandom;
         pat = '0;
         len = 0;
         for (int b = 0; b < 4; b++) begin
            len      = len + int'($urandom_range(0, 2));
            pat[len] = 1'b1;
            len++;
         end
         expLine = isRd ? llc_cacheline'(beats) : lastLine;
         applyStimulus(isRd, 1'b0, $urandom, wline, pat, len + 1, beats, expLine,
                       $sformatf("rnd%0d", n));
         for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
            busIf.resp_i  = $urandom_range(0, 1) == 1;
            busIf.burst_i = {$urandom, $urandom};
            @(negedge clk);
            checkOutput($sformatf("rnd%0d_idleResp", n), resp_o, 1'b0);
            checkOutput($sformatf("rnd%0d_idleLine", n), line_o, lastLine);
         end
         busIf.resp_i = 1'b0;
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
